// File: rtl/axi_wr_burst_ctrl.sv
// AXI write-burst engine: one cache write at a time, either a full line (INCR burst)
// or a single uncached word, sequenced through the AW, W and B phases.
module axi_wr_burst_ctrl #(
    parameter logic [3:0]  AXI_ID     = 4'd1,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req_i,
    input  logic [2:0]                wr_type_i,
    input  logic [31:0]               wr_addr_i,
    input  logic [3:0]                wr_wstrb_i,
    input  logic [32*LINE_BEATS-1:0]  wr_data_i,
    output logic                      wr_rdy_o,
    output logic                      wr_done_o,
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int unsigned CntW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_line;
    logic [31:0]               r_addr;
    logic [3:0]                r_wstrb;
    logic [32*LINE_BEATS-1:0]  r_data;
    logic [CntW-1:0]           r_cnt;
    logic [7:0]                w_len;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_unused_b;

    // Write responses are not checked, so bid/bresp carry no information for us.
    assign w_unused_b = ^{bid, bresp};

    assign w_accept = (r_state == StIdle) && wr_req_i;
    assign w_len    = r_line ? 8'(LINE_BEATS - 1) : 8'd0;
    assign w_last   = (8'(r_cnt) == w_len);

    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line  <= 1'b0;
            r_addr  <= 32'h0;
            r_wstrb <= 4'h0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_line  <= (wr_type_i == 3'b100);
            // Line bursts always start on the line boundary.
            r_addr  <= (wr_type_i == 3'b100) ? {wr_addr_i[31:4], 4'h0} : wr_addr_i;
            r_wstrb <= wr_wstrb_i;
            r_data  <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == StAw) && awready) begin
            r_cnt <= '0;
        end else if ((r_state == StW) && wready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wr_rdy_o    = 1'b0;
        wr_done_o   = 1'b0;
        awid        = 4'h0;
        awaddr      = 32'h0;
        awlen       = 8'h0;
        awsize      = 3'b000;
        awburst     = 2'b00;
        awvalid     = 1'b0;
        wid         = 4'h0;
        wdata       = 32'h0;
        wstrb       = 4'h0;
        wlast       = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        unique case (r_state)
            StIdle: begin
                wr_rdy_o = 1'b1;
                if (wr_req_i) w_state_nxt = StAw;
            end
            StAw: begin
                awvalid = 1'b1;
                awid    = AXI_ID;
                awaddr  = r_addr;
                awlen   = w_len;
                awsize  = 3'b010;
                awburst = 2'b01;
                if (awready) w_state_nxt = StW;
            end
            StW: begin
                wvalid = 1'b1;
                wid    = AXI_ID;
                wdata  = r_data[32*r_cnt +: 32];
                wstrb  = r_line ? 4'hF : r_wstrb;
                wlast  = w_last;
                if (wready && w_last) w_state_nxt = StB;
            end
            StB: begin
                bready = 1'b1;
                if (bvalid) begin
                    wr_done_o   = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule

// File: doc/axi_wr_burst_ctrl.md
Name: axi_wr_burst_ctrl

Overview:
Write-side engine between the data cache's write interface and the AXI master write channels (AW/W/B). Accepts one write request at a time, either a 128-bit cache line (4-beat INCR burst) or a single 32-bit uncached word (1 beat). Issues the address phase, streams the data beats, and waits for the write response. Signals the cache ready only when idle, so a dirty-line eviction can never overlap a second write.

Parameters:
AXI_ID, 4'd1, value driven on awid and wid
LINE_BEATS, 4, beats per cache line (awlen = LINE_BEATS-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_req_i  in  1  write request from cache
wr_type_i  in  3  3'b100 = cache line; 3'b010 = single word; any other value is treated as single word
wr_addr_i  in  32  start byte address
wr_wstrb_i  in  4  byte strobe, used only for single word
wr_data_i  in  128  line data, beat0 = [31:0]; single word uses [31:0]
wr_rdy_o  out  1  engine idle, can accept a request
wr_done_o  out  1  one-cycle pulse when the B response is accepted
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI AW channel
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W channel
wready  in  1
bid/bresp  in  4/2  ignored
bvalid  in  1
bready  out  1

Behaviour:
- States: IDLE, AW, W, B. Reset puts the engine in IDLE with all outputs 0 except wr_rdy_o = 1. Reset mid-burst abandons the transaction and drops all valids immediately.
- wr_rdy_o = (state==IDLE). Accept when wr_req_i & wr_rdy_o. On accept, latch addr/type/wstrb/data and go to AW. Inputs are ignored outside IDLE.
- AW: awvalid = 1. Address, len and size are held stable until awready.
  - awaddr = latched addr. For a line request, bits [3:0] are forced to 0.
  - awlen = 3 for a line, 0 for a word.
  - awsize = 3'b010; awburst = 2'b01.
  - awlock = 0, awcache = 0, awprot = 0.
- awvalid & awready: go to W and clear the beat counter (2 bits).
- W: wvalid = 1.
  - wdata = latched_data[32*cnt +: 32].
  - wstrb = 4'hF for a line, latched wstrb for a word.
  - wlast = (cnt == awlen).
  - On wvalid & wready, cnt increments. When the handshake has wlast = 1, go to B.
  - No W beat before the AW handshake. wvalid is never deasserted mid-burst.
- B: bready = 1. On bvalid, pulse wr_done_o for one cycle and go to IDLE. wr_rdy_o returns high on the cycle after bvalid.
- Minimum latency, accept to wr_done_o, with all ready/valid inputs held high:
  - line: 1 (AW) + 4 (W) + 1 (B) = 6 cycles
  - word: 3 cycles
- awready or wready low holds the current state and outputs; no timeout.
- bvalid arriving while not in B is ignored.
- bresp errors are not reported.

Test Plan:
- Line write, all readies high: addr 0x1C00_0014, data {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA} (beat0 = 0xAAAA) -> awaddr 0x1C00_0010, awlen 3; wdata AAAA, BBBB, CCCC, DDDD on consecutive cycles; wlast on beat 3; wr_done_o 6 cycles after accept.
- Word write, type 3'b010, addr 0xBFAF_8004, wstrb 4'b0011, data[31:0] 0x1234_5678 -> awlen 0, wstrb 0011, wdata 0x12345678 with wlast = 1, wr_done_o after 3 cycles.
- Backpressure: awready low for 3 cycles, then wready toggling 1,0,1,0 -> awaddr/awlen stable while awvalid waits; each beat held until accepted; 4 beats in order; no W before the AW handshake.
- Busy rejection: second wr_req_i asserted during W with addr 0x0 -> ignored, wr_rdy_o stays 0; first transaction completes unchanged.
- Reset mid-burst: assert rst after beat 1 -> awvalid/wvalid/bready drop to 0 at once, wr_rdy_o = 1; a new word write afterwards completes normally.
- Late B: bvalid delayed 10 cycles -> bready held high, wr_done_o pulses exactly once, in the cycle bvalid is sampled.
